// File: rtl/mem_rd_shifter_if.sv
// Load read-path bus between the RAM/core request side and the load-data aligner.
// The requester drives the RAM word and the access controls; the aligner returns the
// shifted, masked, zero-extended load data.
interface mem_rd_shifter_if #(
  parameter int WORD_WIDTH = 32,
  parameter int NUM_COL    = 4
);
  logic [WORD_WIDTH-1:0] ram_read_data;
  logic [WORD_WIDTH-1:0] rd_addr;
  logic [NUM_COL-1:0]    which_bytes;
  logic [WORD_WIDTH-1:0] shifted_data;

  modport master (
    output ram_read_data,
    output rd_addr,
    output which_bytes,
    input  shifted_data
  );

  modport slave (
    input  ram_read_data,
    input  rd_addr,
    input  which_bytes,
    output shifted_data
  );
endinterface

// File: rtl/mem_rd_shifter.sv
// Load-data aligner for the data-memory read path.
// The byte offset and byte-enable of a load are captured alongside the RAM read request so
// that they line up with the word the RAM returns one cycle later. That word is right-shifted
// by the captured byte offset. Each lane is then kept or zeroed by the captured byte-enable.
// The result is zero-extended; any sign extension happens downstream in the core.
module mem_rd_shifter #(
  parameter int WORD_WIDTH = 32,
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8
) (
  input logic                clk,
  input logic                reset_n,
  mem_rd_shifter_if.slave    bus
);

  localparam int OFF_W = $clog2(NUM_COL);
  localparam int SH_W  = $clog2(WORD_WIDTH);

  logic [OFF_W-1:0]      off_q;
  logic [OFF_W-1:0]      off_d;
  logic [NUM_COL-1:0]    be_q;
  logic [NUM_COL-1:0]    be_d;
  logic [SH_W-1:0]       shamt_s;
  logic [WORD_WIDTH-1:0] tmp_s;
  logic [WORD_WIDTH-1:0] data_s;
  logic                  unused_addr_s;

  // Only the byte-within-word bits of the address matter; the word index is the RAM's business.
  assign unused_addr_s = ^bus.rd_addr[WORD_WIDTH-1:OFF_W];

  // Next-state for the control registers: unconditional capture every cycle.
  always_comb begin
    off_d = bus.rd_addr[OFF_W-1:0];
    be_d  = bus.which_bytes;
  end

  // Control registers aligned with the RAM's one-cycle read latency; async clear zeroes the output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      off_q <= {OFF_W{1'b0}};
      be_q  <= {NUM_COL{1'b0}};
    end else begin
      off_q <= off_d;
      be_q  <= be_d;
    end
  end

  // Shift the returned word down by the byte offset, then keep only the enabled lanes.
  // Bytes shifted past the top read as zero; non-contiguous masks are applied per lane
  // after the shift without compaction.
  always_comb begin
    shamt_s = SH_W'(off_q) * SH_W'(COL_WIDTH);
    tmp_s   = bus.ram_read_data >> shamt_s;
    data_s  = {WORD_WIDTH{1'b0}};
    for (int k = 0; k < NUM_COL; k++) begin
      if (be_q[k]) begin
        data_s[k*COL_WIDTH +: COL_WIDTH] = tmp_s[k*COL_WIDTH +: COL_WIDTH];
      end else begin
        data_s[k*COL_WIDTH +: COL_WIDTH] = {COL_WIDTH{1'b0}};
      end
    end
  end

  assign bus.shifted_data = data_s;

endmodule

// File: tb/tb_mem_rd_shifter.sv
// Directed self-checking bench for the load-data aligner.
module tb_mem_rd_shifter;

  logic clk;
  logic reset_n;
  int   pass_cnt;
  int   total_cnt;

  mem_rd_shifter_if #(.WORD_WIDTH(32), .NUM_COL(4)) bus ();

  mem_rd_shifter #(.WORD_WIDTH(32), .NUM_COL(4), .COL_WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present controls and RAM word away from the edge, let the edge capture, sample after it.
  task automatic drive_cycle(input logic [31:0] ram, input logic [31:0] addr, input logic [3:0] be);
    @(negedge clk);
    bus.ram_read_data = ram;
    bus.rd_addr       = addr;
    bus.which_bytes   = be;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n           = 1'b0;
    bus.ram_read_data = 32'hDEADBEEF;
    bus.rd_addr       = 32'h0000_0000;
    bus.which_bytes   = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (bus.shifted_data !== 32'h0000_0000)
      $display("FAIL reset_held: got %h expected %h", bus.shifted_data, 32'h0000_0000);
    else pass_cnt++;
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    #1;
    total_cnt++;
    if (bus.shifted_data !== 32'h0000_0000)
      $display("FAIL reset_release_before_edge: got %h expected %h", bus.shifted_data, 32'h0000_0000);
    else pass_cnt++;
  endtask

  task automatic test_aligned_word();
    drive_cycle(32'hDEADBEEF, 32'h0000_1000, 4'b1111);
    total_cnt++;
    if (bus.shifted_data !== 32'hDEADBEEF)
      $display("FAIL aligned_word: got %h expected %h", bus.shifted_data, 32'hDEADBEEF);
    else pass_cnt++;
    drive_cycle(32'hDEADBEEF, 32'hFFFF_FFFC, 4'b1111);
    total_cnt++;
    if (bus.shifted_data !== 32'hDEADBEEF)
      $display("FAIL upper_addr_ignored: got %h expected %h", bus.shifted_data, 32'hDEADBEEF);
    else pass_cnt++;
  endtask

  task automatic test_byte_half();
    drive_cycle(32'hDEADBEEF, 32'h0007_FFB9, 4'b0001);
    total_cnt++;
    if (bus.shifted_data !== 32'h0000_00BE)
      $display("FAIL byte_off1: got %h expected %h", bus.shifted_data, 32'h0000_00BE);
    else pass_cnt++;
    drive_cycle(32'hDEADBEEF, 32'h0000_0002, 4'b0011);
    total_cnt++;
    if (bus.shifted_data !== 32'h0000_DEAD)
      $display("FAIL half_off2: got %h expected %h", bus.shifted_data, 32'h0000_DEAD);
    else pass_cnt++;
    drive_cycle(32'h1234_5678, 32'h0000_0001, 4'b0011);
    total_cnt++;
    if (bus.shifted_data !== 32'h0000_3456)
      $display("FAIL half_off1: got %h expected %h", bus.shifted_data, 32'h0000_3456);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    drive_cycle(32'hDEADBEEF, 32'h0000_0003, 4'b1111);
    total_cnt++;
    if (bus.shifted_data !== 32'h0000_00DE)
      $display("FAIL word_off3: got %h expected %h", bus.shifted_data, 32'h0000_00DE);
    else pass_cnt++;
    drive_cycle(32'hDEADBEEF, 32'h0000_0003, 4'b0001);
    total_cnt++;
    if (bus.shifted_data !== 32'h0000_00DE)
      $display("FAIL byte_off3: got %h expected %h", bus.shifted_data, 32'h0000_00DE);
    else pass_cnt++;
    drive_cycle(32'hDEADBEEF, 32'h0000_0002, 4'b1111);
    total_cnt++;
    if (bus.shifted_data !== 32'h0000_DEAD)
      $display("FAIL word_off2: got %h expected %h", bus.shifted_data, 32'h0000_DEAD);
    else pass_cnt++;
  endtask

  task automatic test_masks();
    drive_cycle(32'h1122_3344, 32'h0000_0000, 4'b0101);
    total_cnt++;
    if (bus.shifted_data !== 32'h0022_0044)
      $display("FAIL noncontig_off0: got %h expected %h", bus.shifted_data, 32'h0022_0044);
    else pass_cnt++;
    drive_cycle(32'h1122_3344, 32'h0000_0001, 4'b1010);
    total_cnt++;
    if (bus.shifted_data !== 32'h0011_2200 && 1'b1)
      ;
    // tmp = 00112233, lanes 1 and 3 kept -> 00002200 | 00000000
    total_cnt--;
    total_cnt++;
    if (bus.shifted_data !== 32'h0000_2200)
      $display("FAIL noncontig_off1: got %h expected %h", bus.shifted_data, 32'h0000_2200);
    else pass_cnt++;
    drive_cycle(32'hDEADBEEF, 32'h0000_0000, 4'b0000);
    total_cnt++;
    if (bus.shifted_data !== 32'h0000_0000)
      $display("FAIL zero_mask: got %h expected %h", bus.shifted_data, 32'h0000_0000);
    else pass_cnt++;
  endtask

  task automatic test_latency();
    drive_cycle(32'hDEADBEEF, 32'h0000_0000, 4'b1111);
    @(negedge clk);
    bus.rd_addr     = 32'h0000_0002;
    bus.which_bytes = 4'b0011;
    #1;
    total_cnt++;
    if (bus.shifted_data !== 32'hDEADBEEF)
      $display("FAIL latency_before_edge: got %h expected %h", bus.shifted_data, 32'hDEADBEEF);
    else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if (bus.shifted_data !== 32'h0000_DEAD)
      $display("FAIL latency_after_edge: got %h expected %h", bus.shifted_data, 32'h0000_DEAD);
    else pass_cnt++;
  endtask

  task automatic test_data_comb();
    drive_cycle(32'hDEADBEEF, 32'h0000_0000, 4'b1111);
    @(negedge clk);
    bus.ram_read_data = 32'hCAFE_F00D;
    #1;
    total_cnt++;
    if (bus.shifted_data !== 32'hCAFE_F00D)
      $display("FAIL data_no_stage: got %h expected %h", bus.shifted_data, 32'hCAFE_F00D);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    drive_cycle(32'hDEADBEEF, 32'h0000_0001, 4'b1111);
    total_cnt++;
    if (bus.shifted_data !== 32'h00DE_ADBE)
      $display("FAIL pre_reset_word_off1: got %h expected %h", bus.shifted_data, 32'h00DE_ADBE);
    else pass_cnt++;
    #2;
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if (bus.shifted_data !== 32'h0000_0000)
      $display("FAIL async_reset_immediate: got %h expected %h", bus.shifted_data, 32'h0000_0000);
    else pass_cnt++;
    @(negedge clk);
    bus.rd_addr     = 32'h0000_0000;
    bus.which_bytes = 4'b1111;
    reset_n         = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if (bus.shifted_data !== 32'hDEADBEEF)
      $display("FAIL resume_after_reset: got %h expected %h", bus.shifted_data, 32'hDEADBEEF);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ram_v [4];
    logic [31:0] addr_v [4];
    logic [3:0]  be_v [4];
    logic [31:0] exp_v [4];
    ram_v[0] = 32'hA1B2_C3D4; addr_v[0] = 32'h0000_0010; be_v[0] = 4'b1111; exp_v[0] = 32'hA1B2_C3D4;
    ram_v[1] = 32'hA1B2_C3D4; addr_v[1] = 32'h0000_0011; be_v[1] = 4'b0001; exp_v[1] = 32'h0000_00C3;
    ram_v[2] = 32'h0F1E_2D3C; addr_v[2] = 32'h0000_0012; be_v[2] = 4'b0011; exp_v[2] = 32'h0000_0F1E;
    ram_v[3] = 32'h0F1E_2D3C; addr_v[3] = 32'h0000_0013; be_v[3] = 4'b0001; exp_v[3] = 32'h0000_000F;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(ram_v[i], addr_v[i], be_v[i]);
      total_cnt++;
      if (bus.shifted_data !== exp_v[i])
        $display("FAIL back_to_back_%0d: got %h expected %h", i, bus.shifted_data, exp_v[i]);
      else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_aligned_word();
    test_byte_half();
    test_overflow();
    test_masks();
    test_latency();
    test_data_comb();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
